// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS32 core datapath.
//   - Load-type encodings carried from decode through MEM into WB.
//   - REG_ZERO: the hard-wired zero register index.
//   - wb_reg_t: field layout of the MEM/WB pipeline register.
package mips_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  // Load-type encodings; values 5..7 are reserved.
  localparam logic [2:0] LT_LB  = 3'd0;
  localparam logic [2:0] LT_LBU = 3'd1;
  localparam logic [2:0] LT_LH  = 3'd2;
  localparam logic [2:0] LT_LHU = 3'd3;
  localparam logic [2:0] LT_LW  = 3'd4;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic             valid;
    logic             reg_wen;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  res;
    logic             load;
    logic [2:0]       ltype;
  } wb_reg_t;

endpackage

// File: rtl/load_align.sv
// load_align: combinational load-data extraction.
//   word       in  32 : memory word holding the addressed data (little-endian)
//   offset     in  2  : byte offset within the word
//   ltype      in  3  : load type (mips_pkg LT_* encodings)
//   data       out 32 : extracted, sign/zero-extended load value
//   misaligned out 1  : offset illegal for ltype, or ltype reserved
module load_align
  import mips_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  ltype,
  output logic [31:0] data,
  output logic        misaligned
);

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
    logic signed [7:0]  sb;
    logic signed [31:0] sw;
    sb = signed'(b);
    sw = sb;
    return sgn ? 32'(sw) : {24'd0, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
    logic signed [15:0] sh;
    logic signed [31:0] sw;
    sh = signed'(h);
    sw = sh;
    return sgn ? 32'(sw) : {16'd0, h};
  endfunction

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word[{offset, 3'b000} +: 8];
  assign half_sel = word[{offset[1], 4'b0000} +: 16];

  always_comb begin
    data       = '0;
    misaligned = 1'b0;
    case (ltype)
      LT_LB:   data = ext8(byte_sel, 1'b1);
      LT_LBU:  data = ext8(byte_sel, 1'b0);
      LT_LH: begin
        data       = ext16(half_sel, 1'b1);
        misaligned = offset[0];
      end
      LT_LHU: begin
        data       = ext16(half_sel, 1'b0);
        misaligned = offset[0];
      end
      LT_LW: begin
        data       = word;
        misaligned = (offset != 2'd0);
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register and write-back stage.
//   clk, rst            : core clock, synchronous active-high reset
//   mem_*               : instruction leaving MEM (valid, reg_wen, rd,
//                         alu_result/effective address, load, load_type)
//   dmem_rdata          : synchronous data memory read word
//   stall, flush        : hold / squash the WB register (flush wins)
//   rf_wen/rf_rd/rf_wdata : register file write port (RF writes on negedge)
//   fwd_valid/fwd_rd/fwd_data : copy of the write port for EX forwarding
//   addr_err            : misaligned or reserved-type load present in WB
module wb_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_reg_wen,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_alu_result,
  input  logic        mem_load,
  input  logic [2:0]  mem_load_type,
  input  logic [31:0] dmem_rdata,
  input  logic        stall,
  input  logic        flush,
  output logic        rf_wen,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data,
  output logic        addr_err
);

  wb_reg_t     wb;
  logic        held;
  logic [31:0] hold_data;

  logic [31:0] mem_word;
  logic [31:0] ld_data;
  logic        ld_mis;
  logic        misaligned;

  // MEM -> WB register boundary.
  // The memory word is only presented for one cycle, so the first stalled
  // edge of a load snapshots it; later stalled edges keep that snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb   <= '0;
      held <= 1'b0;
    end else if (flush) begin
      wb.valid <= 1'b0;
      held     <= 1'b0;
    end else if (stall) begin
      if (wb.valid && wb.load && !held) begin
        held <= 1'b1;
      end
    end else begin
      wb.valid   <= mem_valid;
      wb.reg_wen <= mem_reg_wen;
      wb.rd      <= mem_rd;
      wb.res     <= mem_alu_result;
      wb.load    <= mem_load;
      wb.ltype   <= mem_load_type;
      held       <= 1'b0;
    end
  end

  // Snapshot datapath; only meaningful while held is set.
  always_ff @(posedge clk) begin
    if (!rst && !flush && stall && wb.valid && wb.load && !held) begin
      hold_data <= dmem_rdata;
    end
  end

  // WB stage: extraction and write-port drive.
  assign mem_word = held ? hold_data : dmem_rdata;

  load_align u_align (
    .word       (mem_word),
    .offset     (wb.res[1:0]),
    .ltype      (wb.ltype),
    .data       (ld_data),
    .misaligned (ld_mis)
  );

  assign misaligned = wb.load & ld_mis;

  assign addr_err  = wb.valid & misaligned;
  assign rf_wen    = wb.valid & wb.reg_wen & (wb.rd != REG_ZERO) & ~misaligned;
  assign rf_rd     = wb.rd;
  assign rf_wdata  = wb.load ? ld_data : wb.res;

  assign fwd_valid = rf_wen;
  assign fwd_rd    = rf_rd;
  assign fwd_data  = rf_wdata;

endmodule
